// File: rtl/io_bank.sv
// io_bank: NPORTS synchronised, strobe-captured input ports and NPORTS latched output ports.
// Latency: in_stb rise at edge k -> port_ready after edge k+2; writes land at the next edge.
// Backpressure: none; port_ready/port_ovr report unread data and overruns. IO_BANK_IRQ_EN adds irq.
module io_bank #(
  parameter int DATA_W = 8,
  parameter int NPORTS = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     re,
  input  logic [SEL_W-1:0]         sel_port,
  input  logic [DATA_W-1:0]        in_RD2,
  input  logic [NPORTS*DATA_W-1:0] in_ports,
  input  logic [NPORTS-1:0]        in_stb,
  output logic [NPORTS*DATA_W-1:0] out_ports,
  output logic [NPORTS-1:0]        out_wstb,
  output logic [DATA_W-1:0]        data_in_from_port,
  output logic [NPORTS-1:0]        port_ready,
`ifdef IO_BANK_IRQ_EN
  input  logic [NPORTS-1:0]        irq_mask,
  output logic                     irq,
`endif
  output logic [NPORTS-1:0]        port_ovr
);

  logic [NPORTS-1:0][DATA_W-1:0] s1_dat, s2_dat, hold, out_reg;
  logic [NPORTS-1:0]             s1_stb, s2_stb, s3_stb;
  logic [NPORTS-1:0]             cap, ack, wsel;

  assign cap       = s2_stb & ~s3_stb;
  assign out_ports = out_reg;

  // Port decode; indices >= NPORTS never match, so they read 0 and write nothing.
  always_comb begin
    ack               = '0;
    wsel              = '0;
    data_in_from_port = '0;
    for (int i = 0; i < NPORTS; i++) begin
      ack[i]  = re && (sel_port == SEL_W'(i));
      wsel[i] = we && (sel_port == SEL_W'(i));
      if (sel_port == SEL_W'(i))
        data_in_from_port = hold[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_dat     <= '0;
      s2_dat     <= '0;
      s1_stb     <= '0;
      s2_stb     <= '0;
      s3_stb     <= '0;
      hold       <= '0;
      out_reg    <= '0;
      out_wstb   <= '0;
      port_ready <= '0;
      port_ovr   <= '0;
    end else begin
      s1_dat   <= in_ports;
      s2_dat   <= s1_dat;
      s1_stb   <= in_stb;
      s2_stb   <= s1_stb;
      s3_stb   <= s2_stb;
      out_wstb <= wsel;
      for (int i = 0; i < NPORTS; i++) begin
        if (wsel[i])
          out_reg[i] <= in_RD2;
        // A capture coinciding with a read consumes the old data, so it is not an overrun.
        if (cap[i]) begin
          hold[i]       <= s2_dat[i];
          port_ready[i] <= 1'b1;
          port_ovr[i]   <= ack[i] ? 1'b0 : (port_ovr[i] | port_ready[i]);
        end else if (ack[i]) begin
          port_ready[i] <= 1'b0;
          port_ovr[i]   <= 1'b0;
        end
      end
    end
  end

`ifdef IO_BANK_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)
      irq <= 1'b0;
    else
      irq <= |(port_ready & irq_mask);
  end
`endif

endmodule

// File: tb/tb_io_bank.sv
// Directed self-checking bench for io_bank (NPORTS=4, DATA_W=8, SEL_W=3).
module tb_io_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [2:0]  sel_port;
  logic [7:0]  in_RD2;
  logic [31:0] in_ports;
  logic [3:0]  in_stb;
  logic [31:0] out_ports;
  logic [3:0]  out_wstb;
  logic [7:0]  data_in_from_port;
  logic [3:0]  port_ready;
  logic [3:0]  port_ovr;
`ifdef IO_BANK_IRQ_EN
  logic [3:0]  irq_mask;
  logic        irq;
`endif

  int ntests = 0;
  int nfail  = 0;

  io_bank #(.DATA_W(8), .NPORTS(4), .SEL_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .re(re),
    .sel_port(sel_port),
    .in_RD2(in_RD2),
    .in_ports(in_ports),
    .in_stb(in_stb),
    .out_ports(out_ports),
    .out_wstb(out_wstb),
    .data_in_from_port(data_in_from_port),
    .port_ready(port_ready),
`ifdef IO_BANK_IRQ_EN
    .irq_mask(irq_mask),
    .irq(irq),
`endif
    .port_ovr(port_ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Strobe rises before the next edge; capture completes on the third edge, then strobe drops and settles.
  task automatic pulse(input int p, input logic [7:0] d);
    in_ports[p*8 +: 8] = d;
    in_stb[p] = 1'b1;
    tick(); tick(); tick();
    in_stb[p] = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b1; we = 1'b1; re = 1'b1; sel_port = 3'd1; in_RD2 = 8'hFF;
    in_ports = '1; in_stb = '1;
`ifdef IO_BANK_IRQ_EN
    irq_mask = '1;
`endif
    tick(); tick();
    chk("rst_out_ports", out_ports, 32'h0);
    chk("rst_ready", {28'h0, port_ready}, 32'h0);
    chk("rst_ovr", {28'h0, port_ovr}, 32'h0);
    chk("rst_wstb", {28'h0, out_wstb}, 32'h0);
    chk("rst_rdata", {24'h0, data_in_from_port}, 32'h0);
`ifdef IO_BANK_IRQ_EN
    chk("rst_irq", {31'h0, irq}, 32'h0);
`endif
    we = 1'b0; re = 1'b0; sel_port = '0; in_RD2 = '0; in_ports = '0; in_stb = '0;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_ready", {28'h0, port_ready}, 32'h0);

    // Capture latency on port 2
    in_ports[23:16] = 8'hA5;
    in_stb[2] = 1'b1;
    tick();
    chk("lat_k", {28'h0, port_ready}, 32'h0);
    tick();
    chk("lat_k1", {28'h0, port_ready}, 32'h0);
    tick();
    chk("lat_k2", {28'h0, port_ready}, 32'h4);
    sel_port = 3'd2;
    #1;
    chk("rd_port2", {24'h0, data_in_from_port}, 32'hA5);
    // Strobe held high: no second capture
    tick(); tick(); tick();
    chk("held_no_ovr", {28'h0, port_ovr}, 32'h0);
    in_stb[2] = 1'b0;
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("rd_clear2", {28'h0, port_ready}, 32'h0);
    tick(); tick();

    // Overrun on port 0
    pulse(0, 8'h11);
    chk("ovr_first_ready", {28'h0, port_ready}, 32'h1);
    chk("ovr_first_noovr", {28'h0, port_ovr}, 32'h0);
    pulse(0, 8'h22);
    chk("ovr_set", {28'h0, port_ovr}, 32'h1);
    sel_port = 3'd0;
    #1;
    chk("ovr_hold", {24'h0, data_in_from_port}, 32'h22);
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("ovr_clr_ready", {28'h0, port_ready}, 32'h0);
    chk("ovr_clr_ovr", {28'h0, port_ovr}, 32'h0);

    // Capture and read collide on port 1
    pulse(1, 8'h0F);
    chk("sim_pre_ready", {28'h0, port_ready}, 32'h2);
    in_ports[15:8] = 8'h3C;
    in_stb[1] = 1'b1;
    tick(); tick();
    sel_port = 3'd1;
    re = 1'b1;
    #1;
    chk("sim_read_old", {24'h0, data_in_from_port}, 32'h0F);
    tick();
    re = 1'b0;
    in_stb[1] = 1'b0;
    chk("sim_ready", {28'h0, port_ready}, 32'h2);
    chk("sim_ovr", {28'h0, port_ovr}, 32'h0);
    chk("sim_new", {24'h0, data_in_from_port}, 32'h3C);
    tick(); tick(); tick();
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("sim_cleanup", {28'h0, port_ready}, 32'h0);

    // Write path
    we = 1'b1; sel_port = 3'd3; in_RD2 = 8'h5A;
    tick();
    we = 1'b0;
    chk("wr3_ports", out_ports, 32'h5A00_0000);
    chk("wr3_wstb", {28'h0, out_wstb}, 32'h8);
    tick();
    chk("wr3_wstb_gone", {28'h0, out_wstb}, 32'h0);
    chk("wr3_hold", out_ports, 32'h5A00_0000);
    we = 1'b1; sel_port = 3'd0; in_RD2 = 8'hC3;
    tick();
    we = 1'b0;
    chk("wr0_ports", out_ports, 32'h5A00_00C3);
    chk("wr0_wstb", {28'h0, out_wstb}, 32'h1);
    we = 1'b1; sel_port = 3'd5; in_RD2 = 8'h77;
    #1;
    chk("rd_oob", {24'h0, data_in_from_port}, 32'h0);
    tick();
    we = 1'b0;
    chk("wr_oob_ports", out_ports, 32'h5A00_00C3);
    chk("wr_oob_wstb", {28'h0, out_wstb}, 32'h0);

`ifdef IO_BANK_IRQ_EN
    irq_mask = 4'b0010;
    pulse(0, 8'h44);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    in_ports[15:8] = 8'h55;
    in_stb[1] = 1'b1;
    tick(); tick(); tick();
    chk("irq_ready1", {28'h0, port_ready}, 32'h3);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    tick();
    in_stb[1] = 1'b0;
    chk("irq_set", {31'h0, irq}, 32'h1);
    sel_port = 3'd1;
    re = 1'b1;
    tick();
    re = 1'b0;
    tick();
    chk("irq_clear", {31'h0, irq}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/io_bank.md
Name: io_bank

Overview:
- Parametrised successor of the processor's 4-port I/O block: NPORTS input ports and NPORTS output ports, each DATA_W bits wide.
- Input side: 2-flop synchronisers, strobe-qualified capture into per-port holding registers, plus ready and overrun status flags cleared by CPU reads.
- Output side: one latched register per port, written from the register-file read bus, with a one-cycle write-valid pulse per port.
- Sits between the datapath (sel_port, we, re, RD2, data_in_from_port) and the chip pins.

Parameters:
- DATA_W, 8, width of each port and of the CPU data bus.
- NPORTS, 4, number of input ports and number of output ports (2..16).
- SEL_W, 2, width of sel_port; must satisfy 2**SEL_W >= NPORTS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  CPU write strobe; writes in_RD2 to the selected output port.
- re  in  1  CPU read strobe; acknowledges (clears) the selected port's ready flag.
- sel_port  in  SEL_W  port index for read and write.
- in_RD2  in  DATA_W  write data from the register file.
- in_ports  in  NPORTS*DATA_W  asynchronous pin data; port i occupies bits [i*DATA_W +: DATA_W].
- in_stb  in  NPORTS  asynchronous per-port "new data" strobe; the event is its rising edge.
- out_ports  out  NPORTS*DATA_W  registered output port values, packed the same way as in_ports.
- out_wstb  out  NPORTS  one-cycle pulse on a port when it has been written.
- data_in_from_port  out  DATA_W  holding register of the selected input port (combinational mux).
- port_ready  out  NPORTS  per-port "unread captured data" flags.
- port_ovr  out  NPORTS  per-port sticky overrun flags.

Behaviour:
- Reset (reset=1 at a clock edge):
  - Clears all synchroniser stages, edge-detect registers, holding registers, out_ports, out_wstb, port_ready and port_ovr to 0.
  - Overrides re and we in that cycle.
  - Asserting reset mid-capture discards the pending event.
- Input synchronisation:
  - in_ports and in_stb each pass through 2 flops (s1, then s2).
  - A third register s3 holds the previous s2 value of the strobe.
- Capture condition: s2_stb[i]=1 and s3_stb[i]=0.
  - On that edge, hold[i] <= s2_data[i] and port_ready[i] <= 1.
  - Latency: strobe high at edge k gives port_ready high after edge k+2.
  - Pin data must be stable from 1 cycle before to 2 cycles after the strobe edge.
- A strobe held high produces exactly one capture.
  - Another capture needs the strobe low for at least one synchronised sample.
- Overrun: a capture while port_ready[i]=1 and not acknowledged in the same cycle:
  - sets port_ovr[i] (sticky);
  - hold[i] takes the new data.
- Read:
  - data_in_from_port = hold[sel_port] at all times.
  - sel_port >= NPORTS reads 0.
  - re=1 clears port_ready[sel_port] and port_ovr[sel_port] at the next edge.
- Simultaneous capture and re on the same port in one cycle:
  - the capture wins; port_ready stays 1 with the new data;
  - port_ovr is cleared, not set (the old data was consumed);
  - the CPU read returns the old hold value.
- Write:
  - we=1 with sel_port < NPORTS: out_ports[sel_port] <= in_RD2 and out_wstb[sel_port] <= 1 for exactly one cycle.
  - All other out_wstb bits are 0.
  - we=1 with sel_port >= NPORTS has no effect.
- we and re may both be asserted in one cycle; they act independently.

Optional Feature:
- Macro IO_BANK_IRQ_EN.
- Defined:
  - Adds input irq_mask (NPORTS bits) and output irq (1 bit).
  - irq is a register: irq <= |(port_ready & irq_mask), giving 1 cycle of lag.
  - irq resets to 0.
- Undefined: neither port exists and no interrupt logic is built.

Test Plan:
- Reset: drive all inputs nonzero with reset=1 for 2 cycles -> out_ports=0, port_ready=0, port_ovr=0, out_wstb=0, data_in_from_port=0.
- Capture latency: in_ports port2=8'hA5, in_stb[2] rises at edge k -> port_ready=4'b0100 after edge k+2; with sel_port=2, data_in_from_port=8'hA5.
- Read-clear and overrun:
  - Capture 8'h11, then 8'h22 on port 0 without a read -> port_ovr[0]=1, hold=8'h22.
  - re with sel_port=0 -> port_ready[0]=0 and port_ovr[0]=0 next cycle.
- Simultaneous capture and read: re on port 1 in the exact capture cycle of 8'h3C (old value 8'h0F) -> read returns 8'h0F; port_ready[1] stays 1 with hold=8'h3C; port_ovr[1]=0.
- Write path: we=1, sel_port=3, in_RD2=8'h5A -> out_ports port3=8'h5A; out_wstb=4'b1000 for one cycle only; other ports unchanged. Then sel_port=5 with SEL_W=3, NPORTS=4 -> no change.
- IRQ (IO_BANK_IRQ_EN defined): irq_mask=4'b0010, capture on port 0 -> irq stays 0; capture on port 1 -> irq=1 one cycle after port_ready[1]; re on port 1 -> irq=0.
